// File: rtl/nrsr_frame_ctrl.sv
// NR/SR frame controller: tracks sensor sync, counts pixels and lines,
// and gates the add_nrsr datapath to a per-frame shadowed window.
module nrsr_frame_ctrl #(
  parameter int W_CNT = 12,
  parameter int W_FRM = 8
) (
  input  logic             clk_72m,
  input  logic             reset,
  input  logic             sens_vs,
  input  logic             sens_hs,
  input  logic             sens_de,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  output logic             nr_en,
  output logic [W_CNT-1:0] pix_cnt,
  output logic [W_CNT-1:0] line_cnt,
  output logic [W_FRM-1:0] frame_cnt,
  output logic             frame_done,
  output logic             err_short,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACT,
    S_DONE
  } state_t;

  localparam logic [W_CNT-1:0] HSZ_RST = W_CNT'(1920);
  localparam logic [W_CNT-1:0] VSZ_RST = W_CNT'(1080);
  localparam logic [W_CNT-1:0] CNT_ONE = W_CNT'(1);
  localparam logic [W_CNT:0]   EXT_ONE = (W_CNT+1)'(1);
  localparam logic [W_FRM-1:0] FRM_ONE = W_FRM'(1);

  state_t state_q, state_d;

  logic vs_q, hs_q;
  logic vs_rise, hs_rise;

  logic             en_q;
  logic [W_CNT-1:0] hst_q, hsz_q;
  logic [W_CNT-1:0] vst_q, vsz_q;

  logic             sen_q;
  logic [W_CNT-1:0] shst_q, shsz_q;
  logic [W_CNT-1:0] svst_q, svsz_q;

  logic [W_CNT-1:0] pix_q, pix_d;
  logic [W_CNT-1:0] line_q, line_d;
  logic             first_q, first_d;
  logic [W_FRM-1:0] fc_q, fc_d;
  logic             err_q, err_d;
  logic             nr_q, nr_d;

  logic             ld_shadow;
  logic             err_set, err_clr;
  logic [W_CNT:0]   pix_x, line_x;
  logic [W_CNT:0]   h_lo, h_hi;
  logic [W_CNT:0]   v_lo, v_hi;
  logic [W_CNT:0]   v_end;
  logic             last_line;
  logic             in_h, in_v;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  assign vs_rise = sens_vs & ~vs_q;
  assign hs_rise = sens_hs & ~hs_q;

  always_ff @(posedge clk_72m) begin
    if (reset) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      vs_q <= sens_vs;
      hs_q <= sens_hs;
    end
  end

  always_ff @(posedge clk_72m) begin
    if (reset) begin
      en_q  <= 1'b0;
      hst_q <= '0;
      hsz_q <= HSZ_RST;
      vst_q <= '0;
      vsz_q <= VSZ_RST;
    end else if (cfg_wr) begin
      unique case (cfg_addr)
        3'd0:    en_q  <= cfg_wdata[0];
        3'd1:    hst_q <= cfg_wdata[W_CNT-1:0];
        3'd2:    hsz_q <= cfg_wdata[W_CNT-1:0];
        3'd3:    vst_q <= cfg_wdata[W_CNT-1:0];
        3'd4:    vsz_q <= cfg_wdata[W_CNT-1:0];
        default: ;
      endcase
    end
  end

  // Shadows sample the live regs before any coincident write lands.
  assign ld_shadow = vs_rise &
                     ((state_q == S_WAIT) |
                      (state_q == S_ACT));

  always_ff @(posedge clk_72m) begin
    if (reset) begin
      sen_q  <= 1'b0;
      shst_q <= '0;
      shsz_q <= HSZ_RST;
      svst_q <= '0;
      svsz_q <= VSZ_RST;
    end else if (ld_shadow) begin
      sen_q  <= en_q;
      shst_q <= hst_q;
      shsz_q <= hsz_q;
      svst_q <= vst_q;
      svsz_q <= vsz_q;
    end
  end

  assign pix_x  = {1'b0, pix_q};
  assign line_x = {1'b0, line_q};
  assign h_lo   = {1'b0, shst_q};
  assign h_hi   = {1'b0, shst_q} + {1'b0, shsz_q};
  assign v_lo   = {1'b0, svst_q};
  assign v_hi   = {1'b0, svst_q} + {1'b0, svsz_q};
  assign v_end  = v_hi - EXT_ONE;

  assign last_line = (svsz_q == '0) | (line_x == v_end);

  assign in_h = (pix_x >= h_lo) & (pix_x < h_hi);
  assign in_v = (line_x >= v_lo) & (line_x < v_hi);

  assign err_set = (state_q == S_ACT) & vs_rise;
  assign err_clr = cfg_wr & (cfg_addr == 3'd0) &
                   cfg_wdata[2];

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    line_d  = line_q;
    first_d = first_q;
    fc_d    = fc_q;
    unique case (state_q)
      S_IDLE: begin
        if (en_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          state_d = S_ACT;
          pix_d   = '0;
          line_d  = '0;
          first_d = 1'b1;
        end
      end
      S_ACT: begin
        if (vs_rise) begin
          pix_d   = '0;
          line_d  = '0;
          first_d = 1'b1;
        end else if (hs_rise) begin
          pix_d   = '0;
          first_d = 1'b0;
          if (!first_q && line_q != '1)
            line_d = line_q + CNT_ONE;
          if (last_line) state_d = S_DONE;
        end else if (sens_de && pix_q != '1) begin
          pix_d = pix_q + CNT_ONE;
        end
      end
      S_DONE: begin
        fc_d    = fc_q + FRM_ONE;
        state_d = en_q ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  assign nr_d = (state_q == S_ACT) & sen_q &
                sens_de & in_h & in_v;

  always_ff @(posedge clk_72m) begin
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
      first_q <= 1'b0;
      fc_q    <= '0;
      err_q   <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      first_q <= first_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
      nr_q    <= nr_d;
    end
  end

  assign nr_en      = nr_q;
  assign pix_cnt    = pix_q;
  assign line_cnt   = line_q;
  assign frame_cnt  = fc_q;
  assign err_short  = err_q;
  assign frame_done = (state_q == S_DONE);
  assign busy       = (state_q == S_ACT) |
                      (state_q == S_DONE);

endmodule

// File: tb/tb_nrsr_frame_ctrl.sv
// Directed bench for nrsr_frame_ctrl: window table plus
// hand sequences for abort, shadowing, wrap and reset.
module tb_nrsr_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sens_vs, sens_hs, sens_de;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        nr_en;
  logic [11:0] pix_cnt, line_cnt;
  logic [7:0]  frame_cnt;
  logic        frame_done, err_short, busy;

  always #5 clk = ~clk;

  nrsr_frame_ctrl dut (
    .clk_72m    (clk),
    .reset      (reset),
    .sens_vs    (sens_vs),
    .sens_hs    (sens_hs),
    .sens_de    (sens_de),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .nr_en      (nr_en),
    .pix_cnt    (pix_cnt),
    .line_cnt   (line_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .err_short  (err_short),
    .busy       (busy)
  );

  typedef struct {
    int hst, hsz, vst, vsz;
    int np, nl;
    int ecnt, esum;
  } row_t;

  row_t tbl [6];

  int vec = 0;
  int bad = 0;
  int tag = 0;
  int tag_s = 0;
  int en_cnt = 0, en_sum = 0;
  int fd_cnt = 0, fd_run = 0, fd_max = 0;
  int c0, s0, f0;
  int exp_fc = 0;

  // tag identifies the pixel (line*16+pix) sampled on each edge
  always @(posedge clk) tag_s <= tag;

  always @(negedge clk) begin
    if (nr_en) begin
      en_cnt = en_cnt + 1;
      en_sum = en_sum + tag_s;
    end
    if (frame_done) begin
      fd_cnt = fd_cnt + 1;
      fd_run = fd_run + 1;
      if (fd_run > fd_max) fd_max = fd_run;
    end else begin
      fd_run = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input int act, input int exp);
    vec = vec + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [15:0] d);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick;
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_win(input int hs0, input int hsz,
                         input int vs0, input int vsz);
    wr(3'd1, 16'(hs0));
    wr(3'd2, 16'(hsz));
    wr(3'd3, 16'(vs0));
    wr(3'd4, 16'(vsz));
  endtask

  task automatic vs_pulse(input logic w,
                          input logic [2:0] a,
                          input logic [15:0] d);
    sens_vs = 1'b1;
    cfg_wr = w;
    cfg_addr = a;
    cfg_wdata = d;
    tick;
    cfg_wr = 1'b0;
    sens_vs = 1'b0;
    tick;
  endtask

  task automatic line(input int l, input int np);
    sens_hs = 1'b1;
    tick;
    sens_hs = 1'b0;
    tick;
    for (int p = 0; p < np; p++) begin
      sens_de = 1'b1;
      tag = l * 16 + p;
      tick;
    end
    sens_de = 1'b0;
    tick;
    tick;
  endtask

  task automatic frame(input int np, input int nl,
                       input logic w,
                       input logic [2:0] a,
                       input logic [15:0] d);
    vs_pulse(w, a, d);
    for (int l = 0; l < nl; l++) line(l, np);
    tick;
    tick;
  endtask

  task automatic snap;
    c0 = en_cnt;
    s0 = en_sum;
    f0 = fd_cnt;
  endtask

  initial begin
    tbl[0] = '{2, 4, 1, 2, 8, 4, 8, 220};
    tbl[1] = '{0, 3, 0, 2, 5, 3, 6, 54};
    tbl[2] = '{1, 0, 0, 3, 6, 4, 0, 0};
    tbl[3] = '{0, 4, 0, 0, 6, 3, 0, 0};
    tbl[4] = '{6, 10, 2, 1, 8, 4, 2, 77};
    tbl[5] = '{7, 1, 1, 3, 8, 5, 3, 117};

    reset = 1'b1;
    sens_vs = 1'b0;
    sens_hs = 1'b0;
    sens_de = 1'b0;
    cfg_wr = 1'b0;
    cfg_addr = 3'd0;
    cfg_wdata = 16'd0;
    tick;
    tick;
    tick;
    chk("rst_nr_en", nr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_err", err_short, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_pix", pix_cnt, 0);
    chk("rst_line", line_cnt, 0);
    reset = 1'b0;
    tick;

    wr(3'd0, 16'h0001);
    tick;
    for (int r = 0; r < 6; r++) begin
      cfg_win(tbl[r].hst, tbl[r].hsz,
              tbl[r].vst, tbl[r].vsz);
      snap;
      frame(tbl[r].np, tbl[r].nl, 1'b0, 3'd0, 16'd0);
      exp_fc = (exp_fc + 1) & 255;
      chk($sformatf("row%0d_cnt", r),
          en_cnt - c0, tbl[r].ecnt);
      chk($sformatf("row%0d_sum", r),
          en_sum - s0, tbl[r].esum);
      chk($sformatf("row%0d_done", r),
          fd_cnt - f0, 1);
      chk($sformatf("row%0d_fcnt", r),
          frame_cnt, exp_fc);
    end

    // h_size write coincident with vs_rise
    cfg_win(2, 4, 1, 2);
    snap;
    frame(8, 4, 1'b1, 3'd2, 16'd6);
    exp_fc = (exp_fc + 1) & 255;
    chk("shd_cur_cnt", en_cnt - c0, 8);
    chk("shd_cur_sum", en_sum - s0, 220);
    snap;
    frame(8, 4, 1'b0, 3'd0, 16'd0);
    exp_fc = (exp_fc + 1) & 255;
    chk("shd_nxt_cnt", en_cnt - c0, 12);
    chk("shd_nxt_sum", en_sum - s0, 342);
    chk("shd_fcnt", frame_cnt, exp_fc);

    // early vs_rise aborts the frame
    cfg_win(0, 8, 0, 4);
    snap;
    vs_pulse(1'b0, 3'd0, 16'd0);
    line(0, 8);
    line(1, 8);
    vs_pulse(1'b0, 3'd0, 16'd0);
    chk("abt_err", err_short, 1);
    chk("abt_line", line_cnt, 0);
    chk("abt_pix", pix_cnt, 0);
    chk("abt_busy", busy, 1);
    chk("abt_done", fd_cnt - f0, 0);
    chk("abt_fcnt", frame_cnt, exp_fc);
    for (int l = 0; l < 5; l++) line(l, 8);
    tick;
    exp_fc = (exp_fc + 1) & 255;
    chk("abt2_done", fd_cnt - f0, 1);
    chk("abt2_cnt", en_cnt - c0, 48);
    chk("abt2_fcnt", frame_cnt, exp_fc);
    chk("abt2_err", err_short, 1);
    wr(3'd0, 16'h0005);
    chk("errclr", err_short, 0);

    // enable dropped mid-frame
    cfg_win(0, 4, 0, 2);
    snap;
    vs_pulse(1'b0, 3'd0, 16'd0);
    line(0, 4);
    wr(3'd0, 16'h0000);
    line(1, 4);
    line(2, 4);
    tick;
    exp_fc = (exp_fc + 1) & 255;
    chk("dis_cnt", en_cnt - c0, 8);
    chk("dis_done", fd_cnt - f0, 1);
    chk("dis_busy", busy, 0);
    vs_pulse(1'b0, 3'd0, 16'd0);
    line(0, 4);
    chk("dis_idle_busy", busy, 0);
    chk("dis_idle_cnt", en_cnt - c0, 8);
    chk("dis_fcnt", frame_cnt, exp_fc);

    // frame counter wrap
    wr(3'd0, 16'h0001);
    cfg_win(0, 1, 0, 0);
    while (exp_fc != 255) begin
      vs_pulse(1'b0, 3'd0, 16'd0);
      line(0, 0);
      exp_fc = (exp_fc + 1) & 255;
    end
    chk("wrap_255", frame_cnt, exp_fc);
    cfg_win(0, 2, 1, 1);
    snap;
    frame(2, 3, 1'b0, 3'd0, 16'd0);
    exp_fc = (exp_fc + 1) & 255;
    chk("wrap_0", frame_cnt, exp_fc);
    chk("wrap_done", fd_cnt - f0, 1);
    chk("wrap_cnt", en_cnt - c0, 2);
    chk("fdone_width", fd_max, 1);

    // reset while nr_en is high
    cfg_win(0, 8, 0, 4);
    vs_pulse(1'b0, 3'd0, 16'd0);
    sens_hs = 1'b1;
    tick;
    sens_hs = 1'b0;
    tick;
    tag = 0;
    sens_de = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (nr_en) break;
    end
    chk("mid_nr_en", nr_en, 1);
    reset = 1'b1;
    tick;
    chk("mrst_nr_en", nr_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    chk("mrst_line", line_cnt, 0);
    chk("mrst_pix", pix_cnt, 0);
    chk("mrst_err", err_short, 0);
    reset = 1'b0;
    sens_de = 1'b0;
    tick;
    snap;
    vs_pulse(1'b0, 3'd0, 16'd0);
    line(0, 8);
    chk("mrst_en_dflt", busy, 0);
    chk("mrst_idle_cnt", en_cnt - c0, 0);
    wr(3'd0, 16'h0001);
    tick;
    chk("mrst_wait", busy, 0);
    vs_pulse(1'b0, 3'd0, 16'd0);
    chk("mrst_act", busy, 1);
    line(0, 8);
    line(1, 8);
    chk("dflt_cnt", en_cnt - c0, 16);
    chk("dflt_sum", en_sum - s0, 184);
    chk("dflt_line", line_cnt, 1);
    chk("dflt_pix", pix_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
